// File: rtl/alu_seq_if.sv
// Operand/result bundle between the control FSM (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic             sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport master (
        output start, op, sign, A, B,
        input  busy, done, result, result_hi, Z, N, C, V
    );

    modport slave (
        input  start, op, sign, A, B,
        output busy, done, result, result_hi, Z, N, C, V
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops plus iterative MUL and (optional) DIV.
// Define ALU_SEQ_DIV_EN to build the restoring divider; without it op 15 reports an illegal op.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; single-cycle ops complete here
    // CALC  | one shift-add / restoring-subtract step per cycle
    // FIX   | sign correction, outputs registered, done pulsed
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nxt;

    localparam logic [3:0] OP_MUL = 4'd14;
    localparam logic [3:0] OP_DIV = 4'd15;

    logic             accept, is_multi;
    logic [SHW-1:0]   cnt, shamt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
    logic             neg_q;
    logic [WIDTH-1:0] res_r, hi_r;
    logic             z_r, n_r, c_r, v_r, done_r;
    logic [WIDTH:0]   add_full, sub_full, mul_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_res, fix_hi;
    logic             fix_z, fix_n, fix_v;
`ifdef ALU_SEQ_DIV_EN
    logic             op_div_q, rneg_q, div0_q, ovf_q;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   rem_sh, div_diff;

    assign is_multi = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, opnd_b};
`else
    assign is_multi = (bus.op == OP_MUL);
`endif

    assign shamt   = bus.B[SHW-1:0];
    assign a_neg   = bus.sign & bus.A[WIDTH-1];
    assign b_neg   = bus.sign & bus.B[WIDTH-1];
    assign a_mag   = a_neg ? -bus.A : bus.A;
    assign b_mag   = b_neg ? -bus.B : bus.B;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (is_multi) state_nxt = CALC;
                end
            end
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_full = {1'b0, bus.A} + {1'b0, bus.B};
        sub_full = {1'b0, bus.A} - {1'b0, bus.B};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (bus.op)
            4'd0:  alu_res = bus.A;
            4'd1:  alu_res = bus.B;
            4'd2:  alu_res = bus.A & bus.B;
            4'd3:  alu_res = bus.A | bus.B;
            4'd4:  alu_res = bus.A ^ bus.B;
            4'd5:  alu_res = ~(bus.A ^ bus.B);
            4'd6:  alu_res = ~bus.A;
            4'd7:  alu_res = ~bus.B;
            4'd8:  alu_res = bus.A << shamt;
            4'd9:  alu_res = bus.A >> shamt;
            4'd10: alu_res = $signed(bus.A) >>> shamt;
            4'd11: alu_res = {bus.A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'd12: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = bus.sign & (bus.A[WIDTH-1] == bus.B[WIDTH-1])
                        & (add_full[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'd13: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = ~sub_full[WIDTH];
                alu_v   = bus.sign & (bus.A[WIDTH-1] != bus.B[WIDTH-1])
                        & (sub_full[WIDTH-1] != bus.A[WIDTH-1]);
            end
            // only op 15 without a divider lands here: illegal-op indication
            default: alu_v = 1'b1;
        endcase
    end

    always_comb begin
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        fix_res  = prod_fix[WIDTH-1:0];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_z    = (prod_fix == '0);
        fix_n    = prod_fix[2*WIDTH-1];
        fix_v    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        if (op_div_q) begin
            fix_res = neg_q  ? -acc_lo : acc_lo;
            fix_hi  = rneg_q ? -acc_hi : acc_hi;
            if (div0_q) begin
                fix_res = '1;
                fix_hi  = a_raw;
                fix_v   = 1'b1;
            end else if (ovf_q) begin
                fix_res = {1'b1, {(WIDTH-1){1'b0}}};
                fix_hi  = '0;
                fix_v   = 1'b1;
            end
            fix_z = (fix_res == '0);
            fix_n = fix_res[WIDTH-1];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd_b <= '0;
            neg_q  <= 1'b0;
            res_r  <= '0;
            hi_r   <= '0;
            z_r    <= 1'b0;
            n_r    <= 1'b0;
            c_r    <= 1'b0;
            v_r    <= 1'b0;
            done_r <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            op_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_raw    <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            if (accept && is_multi) begin
                cnt    <= SHW'(WIDTH - 1);
                acc_hi <= '0;
                acc_lo <= a_mag;
                opnd_b <= b_mag;
                neg_q  <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
                op_div_q <= bus.op[0];
                rneg_q   <= a_neg;
                div0_q   <= (bus.B == '0);
                ovf_q    <= bus.sign && (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
                a_raw    <= bus.A;
`endif
            end else if (accept) begin
                res_r  <= alu_res;
                hi_r   <= '0;
                z_r    <= (alu_res == '0);
                n_r    <= alu_res[WIDTH-1];
                c_r    <= alu_c;
                v_r    <= alu_v;
                done_r <= 1'b1;
            end
            if (state == CALC) begin
                cnt <= cnt - 1'b1;
`ifdef ALU_SEQ_DIV_EN
                if (op_div_q) begin
                    acc_hi <= div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                end
`else
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
`endif
            end
            if (state == FIX) begin
                res_r  <= fix_res;
                hi_r   <= fix_hi;
                z_r    <= fix_z;
                n_r    <= fix_n;
                c_r    <= 1'b0;
                v_r    <= fix_v;
                done_r <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.result    = res_r;
    assign bus.result_hi = hi_r;
    assign bus.Z         = z_r;
    assign bus.N         = n_r;
    assign bus.C         = c_r;
    assign bus.V         = v_r;
endmodule
